// File: rtl/mat_result_streamer.sv
// AXI-Stream result streamer: reads SIZE words from a 1-cycle-latency BRAM and
// emits them as one frame through a 2-entry skid buffer, tlast on the final beat.
module mat_result_streamer #(
    parameter int DIM_LOG    = 1,
    parameter int DIM        = 2**DIM_LOG,
    parameter int SIZE       = DIM*DIM,
    parameter int SIZE_LOG   = 2*DIM_LOG,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [SIZE_LOG-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready
);

    localparam logic [SIZE_LOG:0] SIZE_CNT  = (SIZE_LOG+1)'(SIZE);
    localparam logic [SIZE_LOG:0] LAST_BEAT = (SIZE_LOG+1)'(SIZE - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state, state_nxt;
    logic [SIZE_LOG:0]       issue_cnt, beat_cnt;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   buf_mem [2];
    logic                    head;
    logic [1:0]              count;
    logic                    done_r;
    logic                    valid;
    logic                    pop, last_pop, issue;

    assign valid    = (count != 2'd0);
    assign pop      = valid && m00_axis_tready;
    assign last_pop = pop && (beat_cnt == LAST_BEAT);

    // A read is issued only if its data is guaranteed a free slot on arrival.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                if ((issue_cnt < SIZE_CNT) &&
                    (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop})))
                    issue = 1'b1;
                if (last_pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            inflight   <= 1'b0;
            head       <= 1'b0;
            count      <= 2'd0;
            done_r     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_r   <= last_pop;
            if (state == IDLE && start) begin
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + 1'b1;
                if (pop)   beat_cnt  <= beat_cnt + 1'b1;
            end
            // Tail slot is head offset by occupancy, taken before this cycle's pop.
            if (inflight) buf_mem[head ^ count[0]] <= rd_data;
            if (pop) head <= ~head;
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge s00_axi_aclk) disable iff (!s00_axi_aresetn)
                     !(inflight && (count == 2'd2) && !pop));

    assign busy            = (state == STREAM);
    assign done            = done_r;
    assign rd_en           = issue;
    assign rd_addr         = (state == STREAM) ? issue_cnt[SIZE_LOG-1:0] : '0;
    assign m00_axis_tvalid = valid;
    assign m00_axis_tdata  = valid ? buf_mem[head] : '0;
    assign m00_axis_tstrb  = {(DATA_WIDTH/8){valid}};
    assign m00_axis_tlast  = valid && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_mat_result_streamer.sv
// Bench for mat_result_streamer: a 2x2 instance and a 4x4 instance share one BRAM
// model; every accepted beat is compared with the BRAM contents in address order.
module tb_mat_result_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, ready, sel;
    logic [31:0] bram [16];

    logic        start_a, start_b, ready_a, ready_b;
    logic        busy_a, done_a, rd_en_a, tvalid_a, tlast_a;
    logic        busy_b, done_b, rd_en_b, tvalid_b, tlast_b;
    logic [1:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b, tdata_a, tdata_b;
    logic [3:0]  tstrb_a, tstrb_b;

    logic        cur_busy, cur_done, cur_rd_en, cur_tvalid, cur_tlast;
    logic [3:0]  cur_addr, cur_tstrb;
    logic [31:0] cur_tdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign ready_a = ready && !sel;
    assign ready_b = ready && sel;

    assign cur_busy   = sel ? busy_b   : busy_a;
    assign cur_done   = sel ? done_b   : done_a;
    assign cur_rd_en  = sel ? rd_en_b  : rd_en_a;
    assign cur_addr   = sel ? rd_addr_b : {2'b00, rd_addr_a};
    assign cur_tvalid = sel ? tvalid_b : tvalid_a;
    assign cur_tdata  = sel ? tdata_b  : tdata_a;
    assign cur_tstrb  = sel ? tstrb_b  : tstrb_a;
    assign cur_tlast  = sel ? tlast_b  : tlast_a;

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= bram[rd_addr_a];
        if (rd_en_b) rd_data_b <= bram[rd_addr_b];
    end

    mat_result_streamer #(.DIM_LOG(1)) dut_a (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .m00_axis_tvalid(tvalid_a), .m00_axis_tdata(tdata_a),
        .m00_axis_tstrb(tstrb_a), .m00_axis_tlast(tlast_a), .m00_axis_tready(ready_a)
    );

    mat_result_streamer #(.DIM_LOG(2)) dut_b (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .m00_axis_tvalid(tvalid_b), .m00_axis_tdata(tdata_b),
        .m00_axis_tstrb(tstrb_b), .m00_axis_tlast(tlast_b), .m00_axis_tready(ready_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: low until cycle 11; 2: alternating; 3: random.
    // restart_cyc re-pulses start mid-frame (-1 for none).
    task automatic run_frame(input int size, input int mode, input int restart_cyc);
        int k = 0, last_cyc = -1, rd_cnt = 0, rd_early = 0;
        logic pv = 1'b0;
        logic [31:0] pd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0) || (cyc == restart_cyc);
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc >= 11);
                2:       ready = (cyc % 2 == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            chk("busy", cur_busy, (cyc >= 1) && (last_cyc < 0));
            chk("done", cur_done, (last_cyc >= 0) && (cyc == last_cyc + 1));
            chk("tstrb", cur_tstrb, cur_tvalid ? 4'hF : 4'h0);
            chk("extra_beat", cur_tvalid && (k >= size), 1'b0);
            if (pv) begin
                chk("stall_valid", cur_tvalid, 1'b1);
                chk("stall_data", cur_tdata, pd);
            end
            if (mode == 0) chk("valid_timing", cur_tvalid, (cyc >= 3) && (cyc < 3 + size));
            if (cur_rd_en) begin
                chk("rd_addr", cur_addr, rd_cnt);
                rd_cnt++;
                if (cyc < 11) rd_early++;
            end
            if (cur_tvalid && k < size) begin
                chk("tdata", cur_tdata, bram[k]);
                chk("tlast", cur_tlast, k == size - 1);
            end else begin
                chk("tlast_idle", cur_tlast, 1'b0);
            end
            pv = cur_tvalid && !ready;
            pd = cur_tdata;
            if (cur_tvalid && ready) begin
                k++;
                if (k == size) last_cyc = cyc;
            end
            if (last_cyc >= 0 && cyc == last_cyc + 3) break;
        end
        chk("beats", k, size);
        chk("reads", rd_cnt, size);
        if (mode == 1) chk("rd_before_11", rd_early, 2);
        if (mode == 0) chk("done_cycle", last_cyc + 1, 3 + size);
        start = 1'b0;
    endtask

    initial begin
        sel   = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) bram[i] = 32'h100 + i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs_a", {busy_a, done_a, rd_en_a, rd_addr_a, tvalid_a, tdata_a, tstrb_a, tlast_a}, '0);
        chk("rst_outs_b", {busy_b, done_b, rd_en_b, rd_addr_b, tvalid_b, tdata_b, tstrb_b, tlast_b}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_rd_en", {rd_en_a, rd_en_b, busy_a, busy_b}, 4'b0);
        end

        run_frame(4, 0, -1);
        run_frame(4, 1, -1);
        run_frame(4, 2, 4);
        run_frame(4, 0, -1);
        run_frame(4, 3, -1);

        // Reset in the middle of cycle 5, after beats 0x100 and 0x101 were taken.
        @(posedge clk); #1 start = 1'b1; ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_data", {tvalid_a, tdata_a}, {1'b1, 32'h102});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {tvalid_a, tlast_a, done_a, busy_a}, 4'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {tvalid_a, tlast_a, done_a, rd_en_a}, 4'b0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {tvalid_a, done_a, busy_a, rd_en_a}, 4'b0);
        end
        run_frame(4, 0, -1);

        sel = 1'b1;
        for (int i = 0; i < 16; i++) bram[i] = $urandom;
        run_frame(16, 3, -1);
        run_frame(16, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_result_streamer.md
Name: mat_result_streamer

Overview:
- AXI-Stream master transmitter for the matrix-multiply accelerator's output path.
- On a start pulse from the compute controller, reads all SIZE words of the result BRAM (synchronous read, 1-cycle latency) in address order.
- Streams them on m00_axis with tlast on the final word.
- A 2-entry output buffer hides BRAM latency: one beat per cycle under no backpressure, no data loss under any tready pattern.

Parameters:
- DIM_LOG, 1, matrix dimension in log2.
- DIM, 2**DIM_LOG, matrix dimension.
- SIZE, DIM*DIM, words per frame.
- SIZE_LOG, 2*DIM_LOG, address width.
- DATA_WIDTH, 32, word width in bits.

Ports:
- s00_axi_aclk  in  1  single clock; all logic rising-edge.
- s00_axi_aresetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begin frame.
- busy  out  1  high from the cycle after start is accepted until the last beat is accepted.
- done  out  1  one-cycle pulse after the last beat is accepted.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  SIZE_LOG  BRAM read address.
- rd_data  in  DATA_WIDTH  BRAM read data, valid the cycle after rd_en.
- m00_axis_tvalid  out  1  AXI-Stream valid.
- m00_axis_tdata  out  DATA_WIDTH  AXI-Stream data.
- m00_axis_tstrb  out  DATA_WIDTH/8  byte strobes.
- m00_axis_tlast  out  1  marks beat SIZE-1.
- m00_axis_tready  in  1  AXI-Stream ready.

Behaviour:
- Reset:
  - Asynchronous assert. All outputs 0: busy, done, rd_en, rd_addr, tvalid, tdata, tstrb, tlast.
  - State IDLE, buffer empty, issue and beat counters 0.
  - Reset mid-frame aborts the frame: no tlast, no done. The next frame starts only after a fresh start.
- States: IDLE, STREAM.
  - IDLE: start=1 -> STREAM; issue_cnt=0, beat_cnt=0, busy=1 next cycle.
  - STREAM: start is ignored.
  - STREAM -> IDLE on the cycle the beat with beat_cnt==SIZE-1 is accepted. done=1 and busy=0 in the following cycle; done lasts exactly one cycle.
- Read issue:
  - pop = tvalid && tready.
  - inflight = rd_en registered one cycle.
  - rd_en=1 in STREAM when issue_cnt<SIZE and (count + inflight - pop) < 2, where count is the buffer occupancy (0..2).
  - rd_addr = issue_cnt; issue_cnt increments on each rd_en.
  - rd_addr is 0 and rd_en is 0 in IDLE.
  - rd_en may depend combinationally on tready; no AXI output may.
- Capture: rd_data is written into the buffer tail on the cycle after rd_en. Occupancy never exceeds 2; overflow is a design error flagged by assertion.
- Output:
  - tvalid = buffer non-empty; tdata = buffer head.
  - tstrb = all ones when tvalid, else 0.
  - tlast = tvalid && (beat_cnt==SIZE-1).
  - Once tvalid=1, tvalid/tdata/tlast hold until accepted. tvalid never waits on tready.
  - On pop: head advances, beat_cnt increments.
  - Simultaneous push and pop keeps occupancy unchanged.
- Latency: start high in cycle 0 -> rd_en, rd_addr=0 in cycle 1 -> rd_data in cycle 2 -> tvalid in cycle 3.
- Throughput: with tready held high, beats occupy cycles 3..3+SIZE-1 back-to-back; done in cycle 3+SIZE.
- Data: passed unmodified, no arithmetic. Counters are SIZE_LOG+1 bits, so SIZE is reachable without wrap.

Test Plan:
- Reset asserted for 3 cycles -> every output 0; rd_en stays 0 with start=0 for 20 cycles.
- DIM_LOG=1, BRAM[i]=0x100+i, tready=1, start at cycle 0 -> tdata 0x100..0x103 in cycles 3..6, tlast only in cycle 6, tstrb=0xF, done pulse in cycle 7, busy cycles 1..6.
- Same frame, tready=0 in cycles 0..10, then 1 -> tvalid from cycle 3 with tdata 0x100 held stable, exactly 2 rd_en pulses before cycle 11, then beats 0x100..0x103 in order, no duplicates or drops.
- tready alternating 1/0 from cycle 3 -> 4 beats in order, tdata constant during every stalled cycle, tlast only on 0x103.
- start pulsed again during cycle 4 -> ignored, exactly one frame. Start after done -> second identical frame beginning at rd_addr 0.
- Reset asserted mid-cycle after 2 accepted beats -> tvalid drops immediately, no tlast or done. After release plus start, frame restarts at 0x100. DIM_LOG=2 frame: 16 beats, tlast on the 16th only.
